input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream front end for the ALU/segment lab top.
- Conditions raw board inputs: 5 data switches, 2 control switches, 1 push-button.
- Each debounced button press becomes exactly one single-cycle enable pulse.
- Data and control values are captured on the pulse edge and held stable, so the downstream register-load logic sees clean enable/in/ctrl.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz). Must be >= 2.
- DATA_W, 5: width of data switch bus.
- CTRL_W, 2: width of control switch bus.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- btn_raw  input  1  asynchronous push-button, active-high, bouncing
- sw_in_raw  input  DATA_W  asynchronous data switches
- sw_ctrl_raw  input  CTRL_W  asynchronous control switches
- enable  output  1  one-cycle pulse per accepted press
- in  output  DATA_W  data switch value captured at the pulse
- ctrl  output  CTRL_W  control switch value captured at the pulse
- btn_level  output  1  debounced button level: 1 in PRESSED/RELEASE_WAIT
- press_count  output  8  number of accepted presses, wraps modulo 256

Behaviour:
- Reset:
  - Reset is synchronous, active-high; clock is clk.
  - rst clears all of the following: synchronizer flops, counter, state=IDLE, enable=0, in=0, ctrl=0, btn_level=0, press_count=0.
- Synchronization:
  - btn_raw, sw_in_raw and sw_ctrl_raw each pass through a 2-flop synchronizer.
  - The FSM and the capture registers use only the synchronized copies (btn_s, sw_in_s, sw_ctrl_s).
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: btn_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - btn_s=0 -> IDLE, cnt<=0 (bounce rejected, no pulse).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
    - Otherwise cnt<=cnt+1.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt<=0; otherwise hold (cnt unchanged, no further pulses while held).
  - RELEASE_WAIT:
    - btn_s=1 -> PRESSED, cnt<=0 (release bounce; no new pulse).
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt<=cnt+1.
- Pulse and capture, on the edge of the PRESS_WAIT->PRESSED transition:
  - enable<=1, in<=sw_in_s, ctrl<=sw_ctrl_s, press_count<=press_count+1 (255->0).
  - enable is 0 on every other edge, so the pulse is exactly 1 cycle wide.
  - in/ctrl hold their value until the next accepted press.
- Latency:
  - Edge 0 is the first edge sampling btn_raw=1 on a clean press.
  - PRESS_WAIT is entered at edge 2; enable is registered high at edge DEBOUNCE_CYCLES+2.
- Switch changes never cause a pulse; only the button does.
- Reset mid-operation:
  - Any state returns to IDLE; a pending pulse is discarded.
  - A button held through reset release must complete a full new debounce (sync delay plus DEBOUNCE_CYCLES) before pulsing.
- rst has priority over all other events in the same cycle.

Decomposition:
- Shared package:
  - state enum, 2-bit encoding IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - default DEBOUNCE_CYCLES constant.
- Sub-module sync_2ff, parameter WIDTH; instantiated once, WIDTH = 1+DATA_W+CTRL_W.
- FSM, counter and capture registers live in input_conditioner.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: sw_in=5'h13, sw_ctrl=2'b01, btn_raw 0->1 held 20 cycles -> exactly one enable pulse at edge 6; in=5'h13, ctrl=01, press_count=1; btn_level=1 until release is debounced.
- Bounce reject: btn_raw high 2 cycles, low 3, high 2, low -> no enable pulse, press_count=0, state returns to IDLE.
- Release bounce: press accepted, then btn_raw 1->0->1 (1 cycle low) ->0 held -> single pulse only, press_count=1, btn_level=0 only after 4 stable low cycles.
- Capture hold: after press with sw_in=5'h1F, change sw_in to 5'h00 while held -> in stays 5'h1F until the next press; next press yields in=5'h00.
- Wrap: 256 clean presses -> press_count returns to 0; 256 enable pulses counted.
- Reset mid-debounce: rst asserted at cnt=2 in PRESS_WAIT with btn held -> no pulse; after rst drops, pulse arrives at edge 6 relative to release of rst; all outputs 0 during reset.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the board input conditioner.
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // 10 ms of stability at a 100 MHz board clock.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/input_conditioner_sync.sv
// Two-flop synchronizer bank for asynchronous board inputs.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the push-button into one enable pulse per press and captures
// the data/control switches alongside that pulse.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int DATA_W          = 5,
   parameter int CTRL_W          = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_raw,
   input  logic [DATA_W-1:0] sw_in_raw,
   input  logic [CTRL_W-1:0] sw_ctrl_raw,
   output logic              enable,
   output logic [DATA_W-1:0] in,
   output logic [CTRL_W-1:0] ctrl,
   output logic              btn_level,
   output logic [7:0]        press_count
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int SYNC_W = 1 + DATA_W + CTRL_W;

   logic [SYNC_W-1:0] sync_raw, sync_out;
   logic              btn_s;
   logic [DATA_W-1:0] sw_in_s;
   logic [CTRL_W-1:0] sw_ctrl_s;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              enable_q, enable_d;
   logic [DATA_W-1:0] in_q, in_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [7:0]        press_count_q, press_count_d;
   logic              cnt_last;

   assign sync_raw = {btn_raw, sw_in_raw, sw_ctrl_raw};

   sync_2ff #(.WIDTH(SYNC_W)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sync_raw),
      .q   (sync_out)
   );

   assign {btn_s, sw_in_s, sw_ctrl_s} = sync_out;
   assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         enable_q      <= 1'b0;
         in_q          <= '0;
         ctrl_q        <= '0;
         press_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         enable_q      <= enable_d;
         in_q          <= in_d;
         ctrl_q        <= ctrl_d;
         press_count_q <= press_count_d;
      end
   end

   // Any disagreement during a wait window restarts the debounce from scratch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      enable_d      = 1'b0;
      in_d          = in_q;
      ctrl_d        = ctrl_q;
      press_count_d = press_count_q;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_last) begin
               state_d       = PRESSED;
               enable_d      = 1'b1;
               in_d          = sw_in_s;
               ctrl_d        = sw_ctrl_s;
               press_count_d = press_count_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      btn_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
   end

   assign enable      = enable_q;
   assign in          = in_q;
   assign ctrl        = ctrl_q;
   assign press_count = press_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed checking of input_conditioner against a
// run-length model of the debounced button.
module tb_input_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_raw = 1'b0;
   logic [4:0] sw_in_raw = '0;
   logic [1:0] sw_ctrl_raw = '0;
   logic       enable;
   logic [4:0] in;
   logic [1:0] ctrl;
   logic       btn_level;
   logic [7:0] press_count;

   int checks = 0;
   int failures = 0;
   int pulse_total = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(D), .DATA_W(5), .CTRL_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .sw_in_raw   (sw_in_raw),
      .sw_ctrl_raw (sw_ctrl_raw),
      .enable      (enable),
      .in          (in),
      .ctrl        (ctrl),
      .btn_level   (btn_level),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   // Reference: the FSM sees each input two edges after it is sampled; the
   // debounced level flips after D+1 consecutive samples disagreeing with it.
   bit         model_on = 1'b0;
   bit         h_b [0:1];
   logic [4:0] h_i [0:1];
   logic [1:0] h_c [0:1];
   bit         m_level = 1'b0;
   int         m_run = 0;
   bit         m_enable = 1'b0;
   logic [4:0] m_in = '0;
   logic [1:0] m_ctrl = '0;
   logic [7:0] m_count = '0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            model_on = 1'b1;
            for (int k = 0; k < 2; k++) begin
               h_b[k] = 1'b0;
               h_i[k] = '0;
               h_c[k] = '0;
            end
            m_level = 1'b0;
            m_run = 0;
            m_enable = 1'b0;
            m_in = '0;
            m_ctrl = '0;
            m_count = '0;
         end else begin
            m_enable = 1'b0;
            if (h_b[1] != m_level) begin
               m_run++;
               if (m_run == D + 1) begin
                  m_level = h_b[1];
                  m_run = 0;
                  if (m_level) begin
                     m_enable = 1'b1;
                     m_in = h_i[1];
                     m_ctrl = h_c[1];
                     m_count = m_count + 8'd1;
                  end
               end
            end else begin
               m_run = 0;
            end
            h_b[1] = h_b[0];
            h_i[1] = h_i[0];
            h_c[1] = h_c[0];
            h_b[0] = btn_raw;
            h_i[0] = sw_in_raw;
            h_c[0] = sw_ctrl_raw;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            if (enable === 1'b1) pulse_total++;
            checkOutput("model_enable", {31'd0, enable}, {31'd0, m_enable});
            checkOutput("model_in", {27'd0, in}, {27'd0, m_in});
            checkOutput("model_ctrl", {30'd0, ctrl}, {30'd0, m_ctrl});
            checkOutput("model_btn_level", {31'd0, btn_level}, {31'd0, m_level});
            checkOutput("model_press_count", {24'd0, press_count}, {24'd0, m_count});
         end
      end
   end

   task automatic applyStimulus(input logic b, input logic [4:0] si, input logic [1:0] sc,
                                input logic r, input int hold);
      @(negedge clk);
      btn_raw = b;
      sw_in_raw = si;
      sw_ctrl_raw = sc;
      rst = r;
      repeat (hold) @(posedge clk);
   endtask

   // Edge 0 is the first posedge after the last applyStimulus call.
   task automatic watchEdges(input int window, output int first_pulse, output int pulses,
                             output int level_change);
      logic prev;
      first_pulse = -1;
      pulses = 0;
      level_change = -1;
      prev = btn_level;
      for (int e = 0; e < window; e++) begin
         @(posedge clk);
         #1;
         if (enable === 1'b1) begin
            pulses++;
            if (first_pulse < 0) first_pulse = e;
         end
         if (btn_level !== prev && level_change < 0) level_change = e;
         prev = btn_level;
      end
   endtask

   int fp, np, lc, base;

   initial begin
      applyStimulus(0, 5'h00, 2'b00, 1, 3);

      // Clean press
      applyStimulus(0, 5'h13, 2'b01, 0, 3);
      applyStimulus(1, 5'h13, 2'b01, 0, 0);
      watchEdges(20, fp, np, lc);
      checkOutput("clean_pulse_edge", fp, 6);
      checkOutput("clean_pulse_count", np, 1);
      checkOutput("clean_level_rise_edge", lc, 6);
      checkOutput("clean_in", {27'd0, in}, 32'h13);
      checkOutput("clean_ctrl", {30'd0, ctrl}, 32'h1);
      checkOutput("clean_press_count", {24'd0, press_count}, 32'd1);
      applyStimulus(0, 5'h13, 2'b01, 0, 0);
      watchEdges(12, fp, np, lc);
      checkOutput("clean_release_edge", lc, 6);
      checkOutput("clean_release_pulses", np, 0);

      // Bounce reject
      applyStimulus(0, 5'h00, 2'b00, 1, 2);
      base = pulse_total;
      applyStimulus(1, 5'h07, 2'b10, 0, 2);
      applyStimulus(0, 5'h07, 2'b10, 0, 3);
      applyStimulus(1, 5'h07, 2'b10, 0, 2);
      applyStimulus(0, 5'h07, 2'b10, 0, 12);
      checkOutput("bounce_pulses", pulse_total - base, 0);
      checkOutput("bounce_press_count", {24'd0, press_count}, 32'd0);
      checkOutput("bounce_level", {31'd0, btn_level}, 32'd0);

      // Release bounce
      applyStimulus(0, 5'h0A, 2'b11, 1, 2);
      base = pulse_total;
      applyStimulus(1, 5'h0A, 2'b11, 0, 0);
      watchEdges(10, fp, np, lc);
      checkOutput("relb_pulse_edge", fp, 6);
      applyStimulus(0, 5'h0A, 2'b11, 0, 1);
      applyStimulus(1, 5'h0A, 2'b11, 0, 1);
      applyStimulus(0, 5'h0A, 2'b11, 0, 0);
      watchEdges(12, fp, np, lc);
      checkOutput("relb_level_drop_edge", lc, 6);
      checkOutput("relb_total_pulses", pulse_total - base, 1);
      checkOutput("relb_press_count", {24'd0, press_count}, 32'd1);

      // Capture hold
      applyStimulus(0, 5'h1F, 2'b01, 1, 2);
      applyStimulus(0, 5'h1F, 2'b01, 0, 3);
      applyStimulus(1, 5'h1F, 2'b01, 0, 0);
      watchEdges(10, fp, np, lc);
      checkOutput("hold_pulse_edge", fp, 6);
      applyStimulus(1, 5'h00, 2'b01, 0, 10);
      checkOutput("hold_in_kept", {27'd0, in}, 32'h1F);
      applyStimulus(0, 5'h00, 2'b10, 0, 12);
      checkOutput("hold_in_after_release", {27'd0, in}, 32'h1F);
      applyStimulus(1, 5'h00, 2'b10, 0, 0);
      watchEdges(10, fp, np, lc);
      checkOutput("hold_second_pulse_edge", fp, 6);
      checkOutput("hold_second_in", {27'd0, in}, 32'h00);
      checkOutput("hold_second_ctrl", {30'd0, ctrl}, 32'h2);
      checkOutput("hold_press_count", {24'd0, press_count}, 32'd2);
      applyStimulus(0, 5'h00, 2'b10, 0, 12);

      // Reset mid-debounce with the button held throughout
      base = pulse_total;
      applyStimulus(1, 5'h15, 2'b11, 0, 5);
      applyStimulus(1, 5'h15, 2'b11, 1, 2);
      #1;
      checkOutput("rst_enable", {31'd0, enable}, 32'd0);
      checkOutput("rst_in", {27'd0, in}, 32'd0);
      checkOutput("rst_ctrl", {30'd0, ctrl}, 32'd0);
      checkOutput("rst_btn_level", {31'd0, btn_level}, 32'd0);
      checkOutput("rst_press_count", {24'd0, press_count}, 32'd0);
      applyStimulus(1, 5'h15, 2'b11, 0, 0);
      watchEdges(10, fp, np, lc);
      checkOutput("rst_pulse_edge", fp, 6);
      checkOutput("rst_total_pulses", pulse_total - base, 1);
      checkOutput("rst_after_in", {27'd0, in}, 32'h15);
      applyStimulus(0, 5'h15, 2'b11, 0, 12);

      // Wrap after 256 presses
      applyStimulus(0, 5'h00, 2'b00, 1, 2);
      base = pulse_total;
      for (int p = 0; p < 256; p++) begin
         applyStimulus(1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 0, 8);
         applyStimulus(0, sw_in_raw, sw_ctrl_raw, 0, 8);
      end
      checkOutput("wrap_pulses", pulse_total - base, 256);
      checkOutput("wrap_press_count", {24'd0, press_count}, 32'd0);

      // Random bouncing with occasional resets
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 49) == 0)
            applyStimulus(btn_raw, sw_in_raw, sw_ctrl_raw, 1, $urandom_range(1, 2));
         else
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)), 0, $urandom_range(1, 10));
      end
      applyStimulus(0, 5'h00, 2'b00, 0, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
